// File: rtl/md_unit.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models multi-cycle
// mult/div latency with a countdown, and requests D-stage stalls while busy.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_md_op,
    input  logic        e_start,
    input  logic [31:0] e_rs_data,
    input  logic [31:0] e_rt_data,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Signed product via sign-extension; low 64 bits of the wide product are exact.
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {remainder, quotient}; a zero divisor is replaced to keep the result defined.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = (b == 32'd0) ? 32'd1 : b;
        return {a % d, a / d};
    endfunction

    // Magnitude division avoids the INT_MIN / -1 overflow: the negated
    // quotient 0x80000000 and zero remainder fall out naturally.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
            mb = 32'd1;
        end else begin
            mb = mb;
        end
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (a[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             pend_wr_q;

    logic             is_md_long_s;
    logic             start_md_s;
    logic             mt_hi_s;
    logic             mt_lo_s;
    logic             div_zero_s;
    logic [CNT_W-1:0] cnt_load_s;
    logic [63:0]      result_s;
    logic [31:0]      md_rdata_s;

    // Decode the E-stage op and precompute the arithmetic result.
    always_comb begin
        is_md_long_s = 1'b0;
        cnt_load_s   = CNT_ZERO;
        result_s     = 64'd0;
        div_zero_s   = 1'b0;
        mt_hi_s      = 1'b0;
        mt_lo_s      = 1'b0;
        case (e_md_op)
            OP_MULT: begin
                is_md_long_s = 1'b1;
                cnt_load_s   = MULT_CNT;
                result_s     = mul_signed(e_rs_data, e_rt_data);
            end
            OP_MULTU: begin
                is_md_long_s = 1'b1;
                cnt_load_s   = MULT_CNT;
                result_s     = mul_unsigned(e_rs_data, e_rt_data);
            end
            OP_DIV: begin
                is_md_long_s = 1'b1;
                cnt_load_s   = DIV_CNT;
                result_s     = div_signed(e_rs_data, e_rt_data);
                div_zero_s   = (e_rt_data == 32'd0);
            end
            OP_DIVU: begin
                is_md_long_s = 1'b1;
                cnt_load_s   = DIV_CNT;
                result_s     = div_unsigned(e_rs_data, e_rt_data);
                div_zero_s   = (e_rt_data == 32'd0);
            end
            OP_MTHI: begin
                mt_hi_s = e_start && (state_q == ST_IDLE);
            end
            OP_MTLO: begin
                mt_lo_s = e_start && (state_q == ST_IDLE);
            end
            default: begin
                is_md_long_s = 1'b0;
            end
        endcase
        start_md_s = e_start && is_md_long_s && (state_q == ST_IDLE);
    end

    // Read mux for MFHI/MFLO into the E-stage result path.
    always_comb begin
        md_rdata_s = 32'd0;
        case (e_md_op)
            OP_MFHI: md_rdata_s = hi_q;
            OP_MFLO: md_rdata_s = lo_q;
            default: md_rdata_s = 32'd0;
        endcase
    end

    // Sequencer FSM: HI/LO commit on the same edge that drops busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_md_s) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= cnt_load_s;
                        pend_hi_q <= result_s[63:32];
                        pend_lo_q <= result_s[31:0];
                        pend_wr_q <= ~div_zero_s;
                    end else if (mt_hi_s) begin
                        hi_q <= e_rs_data;
                    end else if (mt_lo_s) begin
                        lo_q <= e_rs_data;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end else begin
                            hi_q <= hi_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= CNT_ZERO;
                end
            endcase
        end
    end

    // The E-stage start cycle already counts as busy for D-stage freezing.
    assign stall_req = d_is_md & (busy_q | (e_start & is_md_long_s));
    assign busy      = busy_q;
    assign md_rdata  = md_rdata_s;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO, busy and stall values.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  e_md_op;
    logic        e_start;
    logic [31:0] e_rs_data;
    logic [31:0] e_rt_data;
    logic        d_is_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int bcyc;
    int scyc;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_md_op   (e_md_op),
        .e_start   (e_start),
        .e_rs_data (e_rs_data),
        .e_rt_data (e_rt_data),
        .d_is_md   (d_is_md),
        .busy      (busy),
        .stall_req (stall_req),
        .md_rdata  (md_rdata),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one E-stage op, then count busy cycles and D-stage stall cycles until busy drops.
    task automatic run_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic dmd, output int bc, output int sc);
        bc = 0;
        sc = 0;
        e_md_op = op; e_start = 1'b1; e_rs_data = rs; e_rt_data = rt; d_is_md = dmd;
        #1;
        if (stall_req) sc++;
        @(posedge clk); #1;
        e_start = 1'b0; e_md_op = 4'd0;
        #1;
        while (busy && bc < 100) begin
            bc++;
            if (stall_req) sc++;
            @(posedge clk); #2;
        end
        d_is_md = 1'b0;
    endtask

    initial begin
        reset = 1'b1; e_md_op = 4'd0; e_start = 1'b0;
        e_rs_data = 32'd0; e_rt_data = 32'd0; d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rdata", md_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        // 1: MULT -2 * 3 with an MFLO waiting in D
        run_md(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, bcyc, scyc);
        check("t1_busy_cyc", bcyc, 32'd5);
        check("t1_stall_cyc", scyc, 32'd6);
        check("t1_hi", hi, 32'hFFFFFFFF);
        check("t1_lo", lo, 32'hFFFFFFFA);
        e_md_op = 4'd8; e_start = 1'b1; d_is_md = 1'b1;
        #1;
        check("t1_mflo", md_rdata, 32'hFFFFFFFA);
        check("t1_nostall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #2;
        e_start = 1'b0; e_md_op = 4'd0; d_is_md = 1'b0;

        // 2: MULTU max * max
        run_md(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bcyc, scyc);
        check("t2_busy_cyc", bcyc, 32'd5);
        check("t2_hi", hi, 32'hFFFFFFFE);
        check("t2_lo", lo, 32'h00000001);

        // 3: DIV -7/2, DIVU by zero keeps HI/LO, INT_MIN/-1, DIV 7/-2
        run_md(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, bcyc, scyc);
        check("t3_busy_cyc", bcyc, 32'd10);
        check("t3_lo", lo, 32'hFFFFFFFD);
        check("t3_hi", hi, 32'hFFFFFFFF);
        run_md(4'd4, 32'd7, 32'd0, 1'b0, bcyc, scyc);
        check("t3_dz_busy_cyc", bcyc, 32'd10);
        check("t3_dz_lo", lo, 32'hFFFFFFFD);
        check("t3_dz_hi", hi, 32'hFFFFFFFF);
        run_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, bcyc, scyc);
        check("t3_ovf_lo", lo, 32'h80000000);
        check("t3_ovf_hi", hi, 32'h00000000);
        run_md(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, bcyc, scyc);
        check("t3_neg_lo", lo, 32'hFFFFFFFD);
        check("t3_neg_hi", hi, 32'h00000001);

        // 4: MTHI then MFHI next cycle; non-MD instruction in D never stalls
        e_md_op = 4'd5; e_start = 1'b1; e_rs_data = 32'h12345678; d_is_md = 1'b1;
        #1;
        check("t4_mthi_nostall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #2;
        check("t4_busy", {31'd0, busy}, 32'd0);
        e_md_op = 4'd7;
        #1;
        check("t4_mfhi", md_rdata, 32'h12345678);
        check("t4_mfhi_nostall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #2;
        e_start = 1'b0; e_md_op = 4'd0; d_is_md = 1'b0;
        check("t4_mtlo_kept", lo, 32'hFFFFFFFD);
        run_md(4'd3, 32'd100, 32'd7, 1'b0, bcyc, scyc);
        check("t4_addu_stall", scyc, 32'd0);
        check("t4_div_lo", lo, 32'd14);
        check("t4_div_hi", hi, 32'd2);

        // 5: reset in busy cycle 4 of a DIV, then MULT 6*7
        e_md_op = 4'd3; e_start = 1'b1; e_rs_data = 32'd50; e_rt_data = 32'd3;
        @(posedge clk); #2;
        e_start = 1'b0; e_md_op = 4'd0;
        repeat (3) begin
            @(posedge clk); #2;
        end
        check("t5_busy_c4", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_hi", hi, 32'd0);
        check("t5_rst_lo", lo, 32'd0);
        run_md(4'd1, 32'd6, 32'd7, 1'b0, bcyc, scyc);
        check("t5_busy_cyc", bcyc, 32'd5);
        check("t5_lo", lo, 32'd42);
        check("t5_hi", hi, 32'd0);

        // 6: back-to-back MULTs, second issued the cycle busy falls
        run_md(4'd1, 32'd3, 32'd5, 1'b1, bcyc, scyc);
        check("t6_first_stall", scyc, 32'd6);
        check("t6_first_lo", lo, 32'd15);
        run_md(4'd1, 32'h00010000, 32'h00030000, 1'b0, bcyc, scyc);
        check("t6_second_busy", bcyc, 32'd5);
        check("t6_hi", hi, 32'd3);
        check("t6_lo", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
